// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector of a small combinational block, captures its truth table and grades it
// Ports: clk/rst (async, active-high); start requests a sweep from IDLE; drv is the vector driven to the block;
// s_in is the block's output; busy covers SETTLE/SAMPLE; done pulses once per sweep; table_out, pass and
// mismatch_count hold the last graded table until the next done.
module truth_table_sweeper #(
    parameter int N_IN = 3,
    parameter int SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'b0111_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      drv,
    input  logic                 s_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_count
);
    localparam int T = 2**N_IN;
    localparam int W = N_IN + 1;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [T-1:0] cap, cap_nxt, diff;
    logic [W-1:0] pop;
    // grading works on the table including the bit being sampled now, so results land with done
    always_comb begin
        cap_nxt = cap;
        cap_nxt[drv] = s_in;
        diff = cap_nxt ^ EXPECTED;
        pop = '0;
        for (int i = 0; i < T; i++) pop = pop + W'(diff[i]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            cap <= '0;
            drv <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            table_out <= '0;
            pass <= 1'b0;
            mismatch_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_SETTLE;
                    drv <= '0;
                    cnt <= '0;
                    cap <= '0;
                    busy <= 1'b1;
                end
                S_SETTLE: if (cnt == 4'(SETTLE)) state <= S_SAMPLE; else cnt <= cnt + 4'd1;
                S_SAMPLE: begin
                    cap <= cap_nxt;
                    if (drv == {N_IN{1'b1}}) begin
                        state <= S_DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        table_out <= cap_nxt;
                        pass <= (cap_nxt == EXPECTED);
                        mismatch_count <= pop;
                    end else begin
                        drv <= drv + N_IN'(1);
                        cnt <= '0;
                        state <= S_SETTLE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized self-checking bench for three sweepers (SETTLE 0, 1, 3) against a table-level model
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] start, s_in, busy, done, pass;
    logic [2:0] drv [3];
    logic [7:0] tbl [3];
    logic [3:0] mm [3];
    logic [7:0] tt;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign s_in[g] = tt[drv[g]];
        truth_table_sweeper #(.N_IN(3), .SETTLE(g == 0 ? 0 : g == 1 ? 1 : 3), .EXPECTED(8'h70)) u_dut (
            .clk(clk), .rst(rst), .start(start[g]), .drv(drv[g]), .s_in(s_in[g]),
            .busy(busy[g]), .done(done[g]), .table_out(tbl[g]), .pass(pass[g]), .mismatch_count(mm[g])
        );
    end
    function automatic int settle_of(int k);
        return k == 0 ? 0 : k == 1 ? 1 : 3;
    endfunction
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Called at the negedge right after E0; mode 0 leaves start alone, 1 randomizes it, 2 keeps it held.
    task automatic track(int k, logic [7:0] t, int mode);
        int hold = settle_of(k) + 2;
        for (int c = 1; c <= 8 * hold; c++) begin
            check("drv", 32'(drv[k]), 32'((c - 1) / hold));
            check("busy", 32'(busy[k]), 1);
            check("done_early", 32'(done[k]), 0);
            if (mode == 1) start[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("done", 32'(done[k]), 1);
        check("busy_done", 32'(busy[k]), 0);
        check("table", 32'(tbl[k]), 32'(t));
        check("pass", 32'(pass[k]), 32'(t == 8'h70));
        check("mismatch", 32'(mm[k]), 32'($countones(t ^ 8'h70)));
        if (mode == 1) start[k] = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_pulse", 32'(done[k]), 0);
        check("busy_idle", 32'(busy[k]), 0);
    endtask
    task automatic run(int k, logic [7:0] t, int mode);
        tt = t;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        track(k, t, mode);
        start[k] = 1'b0;
        @(negedge clk);
    endtask
    function automatic logic [7:0] default_table();
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = i[2] & (~i[1] | ~i[0]);
        return r;
    endfunction
    initial begin
        rst = 1'b1;
        start = '0;
        tt = default_table();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_drv", 32'(drv[k]), 0);
            check("rst_busy", 32'(busy[k]), 0);
            check("rst_done", 32'(done[k]), 0);
            check("rst_table", 32'(tbl[k]), 0);
            check("rst_pass", 32'(pass[k]), 0);
            check("rst_mm", 32'(mm[k]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        run(1, default_table(), 0);
        run(1, 8'h58, 0);
        tt = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("hold_table", 32'(tbl[1]), 32'h58);
            check("hold_pass", 32'(pass[1]), 0);
            check("hold_mm", 32'(mm[1]), 2);
            @(negedge clk);
        end
        run(1, 8'hFF, 0);
        run(0, default_table(), 0);
        run(2, default_table(), 0);
        for (int i = 0; i < 8; i++) run($urandom_range(0, 2), 8'($urandom), 1);
        tt = default_table();
        start[1] = 1'b1;
        @(negedge clk);
        track(1, default_table(), 2);
        tt = 8'h58;
        @(negedge clk);
        track(1, 8'h58, 2);
        start[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tt = default_table();
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_rst_drv", 32'(drv[1]), 4);
        rst = 1'b1;
        #1;
        check("arst_drv", 32'(drv[1]), 0);
        check("arst_busy", 32'(busy[1]), 0);
        check("arst_done", 32'(done[1]), 0);
        check("arst_table", 32'(tbl[1]), 0);
        check("arst_pass", 32'(pass[1]), 0);
        check("arst_mm", 32'(mm[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            check("post_rst_done", 32'(done[1]), 0);
            check("post_rst_busy", 32'(busy[1]), 0);
            @(negedge clk);
        end
        run(1, default_table(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
